// File: rtl/qspi_raw_if.sv
// qspi_raw_if -- bundle of the raw (Q)SPI slave signals.
//   spi_clk_in, spi_cs_in, spi_data_in[3:0] : bus-master side, asynchronous
//   spi_mode[2:0]                           : lanes per SPI clock (1, 2, 4)
//   spi_data_out[3:0]                       : transmit lanes
//   spi_byte_rx[7:0], spi_byte_tx[7:0]      : received / next transmit byte
//   spi_cmd_strobe, spi_byte_strobe         : one-clk completion pulses
// slave modport: the qspi_raw core; master modport: bus master plus host.
interface qspi_raw_if;
  logic       spi_clk_in;
  logic       spi_cs_in;
  logic [3:0] spi_data_in;
  logic [2:0] spi_mode;
  logic [3:0] spi_data_out;
  logic [7:0] spi_byte_rx;
  logic [7:0] spi_byte_tx;
  logic       spi_cmd_strobe;
  logic       spi_byte_strobe;

  modport slave (
    input  spi_clk_in, spi_cs_in, spi_data_in, spi_mode, spi_byte_tx,
    output spi_data_out, spi_byte_rx, spi_cmd_strobe, spi_byte_strobe
  );

  modport master (
    output spi_clk_in, spi_cs_in, spi_data_in, spi_mode, spi_byte_tx,
    input  spi_data_out, spi_byte_rx, spi_cmd_strobe, spi_byte_strobe
  );
endinterface

// File: rtl/qspi_raw.sv
// qspi_raw -- oversampling SPI / dual / quad slave byte engine.
//   clk   : system clock, everything updates on its rising edge
//   reset : synchronous, active low
//   bus   : qspi_raw_if.slave (SPI pins, lane mode, rx/tx bytes, strobes)
// SPI pins are synchronized into clk, edges found by comparing the
// synchronized SPI clock with a one-clk delayed copy, then handled one clk
// later so a byte strobe lands 3-4 clk after the raw SPI rising edge.
module qspi_raw (
  input  logic       clk,
  input  logic       reset,
  qspi_raw_if.slave  bus
);
  logic [1:0] clk_sync;
  logic [1:0] cs_sync;
  logic [3:0] data_meta;
  logic [3:0] data_sync;
  logic       clk_d;
  logic       rise;
  logic       fall;
  logic       rise_q;
  logic       fall_q;
  logic       cs_q;
  logic [3:0] data_q;
  logic [2:0] sync_ok;
  logic       armed;
  logic       first;
  logic [3:0] cnt;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] byte_rx;
  logic [3:0] data_out;
  logic       byte_strobe;
  logic       cmd_strobe;

  logic [3:0] step;
  logic [3:0] cnt_next;
  logic [7:0] rx_next;
  logic [7:0] tx_src;
  logic [3:0] drive;

  assign rise = clk_sync[1] & ~clk_d;
  assign fall = ~clk_sync[1] & clk_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      data_meta <= '0;
      data_sync <= '0;
      clk_d     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cs_q      <= 1'b1;
      data_q    <= '0;
      sync_ok   <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], bus.spi_clk_in};
      cs_sync   <= {cs_sync[0], bus.spi_cs_in};
      data_meta <= bus.spi_data_in;
      data_sync <= data_meta;
      clk_d     <= clk_sync[1];
      rise_q    <= rise;
      fall_q    <= fall;
      cs_q      <= cs_sync[1];
      data_q    <= data_sync;
      sync_ok   <= {sync_ok[1:0], 1'b1};
    end
  end

  always_comb begin
    case (bus.spi_mode)
      3'd2:    step = 4'd2;
      3'd4:    step = 4'd4;
      default: step = 4'd1;
    endcase
    cnt_next = cnt + step;
    case (step)
      4'd2:    rx_next = {rx_sh[5:0], data_q[1:0]};
      4'd4:    rx_next = {rx_sh[3:0], data_q};
      default: rx_next = {rx_sh[6:0], data_q[0]};
    endcase
    tx_src = (cnt == '0) ? bus.spi_byte_tx : (tx_sh << step);
    case (step)
      4'd2:    drive = {2'b00, tx_src[7:6]};
      4'd4:    drive = tx_src[7:4];
      default: drive = {2'b00, tx_src[7], 1'b0};
    endcase
  end

  // armed: after reset, bytes are only accepted once CS has been seen high
  // through the settled synchronizer (sync_ok masks the reset-value CS=1),
  // so a reset mid-byte cannot resume a partial transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      armed       <= 1'b0;
      first       <= 1'b1;
      cnt         <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      byte_rx     <= '0;
      data_out    <= '0;
      byte_strobe <= 1'b0;
      cmd_strobe  <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      cmd_strobe  <= 1'b0;
      if (sync_ok[2] && cs_q) begin
        armed <= 1'b1;
      end
      if (cs_q) begin
        cnt   <= '0;
        first <= 1'b1;
      end else if (armed) begin
        if (rise_q) begin
          rx_sh <= rx_next;
          if (cnt_next[3]) begin
            byte_rx     <= rx_next;
            cnt         <= '0;
            byte_strobe <= 1'b1;
            cmd_strobe  <= first;
            first       <= 1'b0;
          end else begin
            cnt <= cnt_next;
          end
        end
        if (fall_q) begin
          tx_sh    <= tx_src;
          data_out <= drive;
        end
      end
    end
  end

  assign bus.spi_byte_rx     = byte_rx;
  assign bus.spi_data_out    = data_out;
  assign bus.spi_byte_strobe = byte_strobe;
  assign bus.spi_cmd_strobe  = cmd_strobe;
endmodule

// File: tb/tb_qspi_raw.sv
// tb_qspi_raw -- directed bench for qspi_raw. The SPI clock idles high so a
// falling edge precedes every sampling rising edge; a monitor collects every
// byte strobe and the transmit lanes seen just before each rising edge.
`timescale 1ns/1ps
module tb_qspi_raw;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qspi_raw_if bus();
  qspi_raw dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rx_q[$];
  logic       cmd_q[$];
  logic [3:0] tx_obs[$];
  int   dbl = 0;
  int   orphan = 0;
  logic prev_stb = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.spi_byte_strobe) begin
      rx_q.push_back(bus.spi_byte_rx);
      cmd_q.push_back(bus.spi_cmd_strobe);
    end
    if (bus.spi_cmd_strobe && !bus.spi_byte_strobe) orphan++;
    if (bus.spi_byte_strobe && prev_stb) dbl++;
    prev_stb = bus.spi_byte_strobe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int lanes_of(input int mode);
    return (mode == 2) ? 2 : (mode == 4) ? 4 : 1;
  endfunction

  task automatic send_bits(input logic [7:0] b, input int mode, input int nsteps, input int half);
    logic [7:0] sh;
    int lanes;
    sh = b;
    lanes = lanes_of(mode);
    bus.spi_mode = 3'(mode);
    for (int i = 0; i < nsteps; i++) begin
      bus.spi_clk_in = 1'b0;
      case (lanes)
        2:       bus.spi_data_in = {2'b00, sh[7:6]};
        4:       bus.spi_data_in = sh[7:4];
        default: bus.spi_data_in = {3'b000, sh[7]};
      endcase
      sh = sh << lanes;
      wait_clk(half);
      tx_obs.push_back(bus.spi_data_out);
      bus.spi_clk_in = 1'b1;
      wait_clk(half);
    end
  endtask

  task automatic send_seq(input logic [63:0] bytes, input int n, input int mode, input int half);
    for (int i = 0; i < n; i++)
      send_bits(bytes[8*(n-1-i) +: 8], mode, 8 / lanes_of(mode), half);
  endtask

  task automatic cs_low();
    bus.spi_cs_in = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    bus.spi_cs_in = 1'b1;
    wait_clk(6);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    cmd_q.delete();
    tx_obs.delete();
  endtask

  task automatic check_rx(input string tag, input logic [63:0] exp, input int n);
    chk({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) begin
        chk($sformatf("%s_rx%0d", tag, i), rx_q[i], exp[8*(n-1-i) +: 8]);
        chk($sformatf("%s_cmd%0d", tag, i), cmd_q[i], (i == 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    logic [7:0] pat;
    reset = 1'b0;
    bus.spi_clk_in = 1'b1;
    bus.spi_cs_in = 1'b1;
    bus.spi_data_in = '0;
    bus.spi_mode = 3'd1;
    bus.spi_byte_tx = 8'h00;
    wait_clk(3);
    chk("rst_byte_rx", bus.spi_byte_rx, 0);
    chk("rst_data_out", bus.spi_data_out, 0);
    chk("rst_byte_stb", bus.spi_byte_strobe, 0);
    chk("rst_cmd_stb", bus.spi_cmd_strobe, 0);
    reset = 1'b1;
    wait_clk(8);

    // single lane, five bytes, MISO carries 0x80
    clear_obs();
    bus.spi_byte_tx = 8'h80;
    cs_low();
    send_seq(64'h03A55A0102, 5, 1, 5);
    cs_high();
    check_rx("m1", 64'h03A55A0102, 5);
    for (int i = 0; i < 8; i++)
      chk($sformatf("miso80_%0d", i), tx_obs[i], (i == 0) ? 4'b0010 : 4'b0000);

    // command in single lane, payload in quad; tx A5
    clear_obs();
    bus.spi_byte_tx = 8'hA5;
    cs_low();
    send_seq(64'hEB, 1, 1, 5);
    send_seq(64'hA55A0102, 4, 4, 5);
    cs_high();
    check_rx("q4a", 64'hEBA55A0102, 5);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++)
      chk($sformatf("misoA5_%0d", i), tx_obs[i], pat[7-i] ? 4'b0010 : 4'b0000);
    chk("quad_tx_hi", tx_obs[8], 4'hA);
    chk("quad_tx_lo", tx_obs[9], 4'h5);

    clear_obs();
    cs_low();
    send_seq(64'hEB, 1, 1, 5);
    send_seq(64'h10203040, 4, 4, 5);
    cs_high();
    check_rx("q4b", 64'hEB10203040, 5);

    // dual lane command, then an unsupported mode value acting as single lane
    clear_obs();
    bus.spi_byte_tx = 8'hC6;
    cs_low();
    send_seq(64'h3C, 1, 2, 5);
    send_seq(64'h96, 1, 3, 5);
    cs_high();
    check_rx("m2m3", 64'h3C96, 2);
    chk("dual_tx0", tx_obs[0], 4'h3);
    chk("dual_tx1", tx_obs[1], 4'h0);
    chk("dual_tx2", tx_obs[2], 4'h1);
    chk("dual_tx3", tx_obs[3], 4'h2);

    // partial byte discarded on CS rise
    clear_obs();
    cs_low();
    send_bits(8'hFF, 1, 5, 5);
    cs_high();
    chk("partial_count", rx_q.size(), 0);
    chk("partial_hold", bus.spi_byte_rx, 8'h96);
    clear_obs();
    cs_low();
    send_seq(64'h22, 1, 1, 5);
    cs_high();
    check_rx("after_partial", 64'h22, 1);

    // reset for one clk mid-byte
    clear_obs();
    cs_low();
    send_bits(8'h55, 1, 3, 5);
    reset = 1'b0;
    wait_clk(1);
    reset = 1'b1;
    chk("midrst_byte_rx", bus.spi_byte_rx, 0);
    chk("midrst_data_out", bus.spi_data_out, 0);
    chk("midrst_byte_stb", bus.spi_byte_strobe, 0);
    chk("midrst_cmd_stb", bus.spi_cmd_strobe, 0);
    clear_obs();
    send_bits(8'hA8, 1, 5, 5);
    send_seq(64'h77, 1, 1, 5);
    cs_high();
    chk("postrst_count", rx_q.size(), 0);
    clear_obs();
    cs_low();
    send_seq(64'h11, 1, 1, 5);
    cs_high();
    check_rx("postrst", 64'h11, 1);

    // back-to-back bytes at minimum SPI phase length
    clear_obs();
    cs_low();
    send_seq(64'h123456789A, 5, 1, 3);
    cs_high();
    check_rx("minclk", 64'h123456789A, 5);

    chk("strobe_width", dbl, 0);
    chk("cmd_without_byte", orphan, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/qspi_raw.md
QSPI_RAW -- requirements
Module: qspi_raw

Interface
REQ-001 clk  in  1  system clock; all state and outputs update on its rising edge only.
REQ-002 reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-003 spi_clk_in  in  1  SPI clock from bus master, asynchronous to clk.
REQ-004 spi_cs_in  in  1  chip select, active low, asynchronous.
REQ-005 spi_data_in  in  4  SPI data lanes IO3..IO0; single mode samples IO0 (MOSI), asynchronous.
REQ-006 spi_mode  in  3  lanes per SPI clock: 1, 2 or 4; any other value is treated as 1.
REQ-007 spi_data_out  out  4  transmit lanes; single mode drives IO1 (MISO), quad drives IO3..IO0.
REQ-008 spi_byte_rx  out  8  last complete received byte.
REQ-009 spi_byte_tx  in  8  next byte to transmit.
REQ-010 spi_cmd_strobe  out  1  one-clk pulse: first byte after CS assertion is complete.
REQ-011 spi_byte_strobe  out  1  one-clk pulse: any byte is complete.

Function
REQ-012 spi_clk_in, spi_cs_in and spi_data_in SHALL each pass through a 2-flop synchronizer; all logic uses the synchronized copies.
REQ-013 The SPI clock rising and falling edges SHALL be detected by comparing the synchronized spi_clk with a 1-clk delayed copy.
REQ-014 Supported SPI timing: spi_clk high and low phases each ≥ 3 clk periods; data stable ≥ 1 clk before the SPI rising edge; faster SPI clocks are out of scope.
REQ-015 While CS is high: bit counter = 0, first-byte flag = 1, no strobes.
REQ-016 Each detected SPI rising edge with CS low SHALL shift spi_mode bits MSB-first into the rx shift register and add spi_mode to the 4-bit bit counter.
  Lanes shifted: mode 1 = data[0]; mode 2 = data[1:0]; mode 4 = data[3:0].
REQ-017 When the counter reaches ≥ 8, on that edge:
  - spi_byte_rx gets the assembled byte;
  - the counter returns to 0;
  - spi_byte_strobe pulses for exactly one clk, 3-5 clk after the raw SPI edge.
REQ-018 On the first byte after CS falls, spi_cmd_strobe SHALL pulse in the same clk as spi_byte_strobe; the first-byte flag then clears.
REQ-019 spi_byte_rx SHALL hold its value until the next completed byte.
REQ-020 spi_mode SHALL be sampled on every SPI rising edge; changing it only at byte boundaries is required for correct data (mode 1 → 4 after the command byte).
REQ-021 On each SPI falling edge with CS low and counter = 0, the tx shift register SHALL load spi_byte_tx and drive its first MSB bit(s).
  On later falling edges it shifts left by spi_mode and drives the next bits.
REQ-022 Driving per mode:
  - mode 1: data_out[1] = tx MSB, other lanes 0;
  - mode 2: data_out[1:0] = two MSBs;
  - mode 4: data_out[3:0] = high nibble.
REQ-023 The host updates spi_byte_tx within the SPI low phase following spi_byte_strobe.
REQ-024 CS deasserting mid-byte SHALL discard the partial byte: no strobe, spi_byte_rx unchanged.
REQ-025 CS reasserting SHALL start a new command.
REQ-026 A CS rise and SPI edge in the same clk: CS wins, and the edge is ignored.

Reset
REQ-027 While reset = 0, in the next clk:
  - spi_byte_rx = 0, spi_data_out = 0, both strobes = 0;
  - counter = 0, rx/tx shift registers = 0, first-byte flag = 1;
  - synchronizer and edge-history flops = idle (spi_clk 0, CS 1).
REQ-028 Reset asserted mid-byte SHALL discard the partial byte.
  - After release, no byte completes until CS goes high then low again.

Verification
REQ-029 Mode 1, CS low, send 03 A5 5A 01 02, CS high.
  - Expect 5 byte strobes with spi_byte_rx = 03, A5, 5A, 01, 02.
  - Expect spi_cmd_strobe only with 03.
REQ-030 Mode 1 send EB, switch to mode 4, send A5 5A 01 02 (2 SPI clocks each).
  - Expect rx EB (cmd), then A5, 5A, 01, 02.
  - Repeat with 10 20 30 40, also correct.
REQ-031 spi_byte_tx = 80 before the first falling edge, mode 1.
  - MISO sequence over 8 SPI clocks = 1,0,0,0,0,0,0,0.
  - In mode 4 with tx = A5: data_out = A then 5.
REQ-032 Mode 1, send 5 bits, then CS high.
  - Expect no strobe and spi_byte_rx unchanged.
  - Next CS-low byte 22 gives cmd+byte strobe with 22.
REQ-033 reset = 0 for one clk mid-byte.
  - All outputs = 0 next clk.
  - After a CS cycle, byte 11 is received correctly with cmd strobe.
REQ-034 Strobe width: every strobe is exactly one clk high.
  - Back-to-back bytes at minimum SPI timing: no missed or duplicated strobes.
